// File: rtl/dragon_pkg.sv
// dragon_pkg: shared codes and field layouts for the dragon controller,
// its head stepper and the body shift-register block.
package dragon_pkg;

    localparam int unsigned CNT_W   = 6;   // frame counter width
    localparam int unsigned COORD_W = 4;   // one grid coordinate
    localparam int unsigned POS_W   = 8;   // {x, y} cell
    localparam int unsigned HEAD_W  = 10;  // {orient, x, y} head word
    localparam int unsigned LEN_W   = 3;   // body length

    // Counter value at which the body block shifts; the head word must be
    // stable before the counter reaches it.
    localparam logic [CNT_W-1:0] SHIFT_POINT = 6'd2;
    localparam logic [LEN_W-1:0] MAX_LEN     = 3'd7;

    typedef enum logic [1:0] {
        PULSE_MOVE = 2'b00,
        PULSE_HEAL = 2'b01,
        PULSE_HIT  = 2'b10,
        PULSE_IDLE = 2'b11
    } pulse_t;

    typedef enum logic [1:0] {
        ORIENT_UP    = 2'b00,
        ORIENT_RIGHT = 2'b01,
        ORIENT_DOWN  = 2'b10,
        ORIENT_LEFT  = 2'b11
    } orient_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } cell_t;

    typedef struct packed {
        orient_t            orient;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } head_word_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIT  = 2'd1,
        S_HEAL = 2'd2,
        S_GAP  = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/dragon_head_stepper.sv
// dragon_head_stepper: combinational one-cell step of the head toward a target.
//   cur_head    - current {orient, x, y} head word
//   target      - target cell {x, y}
//   next_head_c - head word after one step (held when already on target)
// Horizontal moves win ties (|dx| == |dy|).
module dragon_head_stepper
    import dragon_pkg::*;
(
    input  head_word_t cur_head,
    input  cell_t      target,
    output head_word_t next_head_c
);

    logic signed [COORD_W:0] dx_c;
    logic signed [COORD_W:0] dy_c;
    logic        [COORD_W:0] adx_c;
    logic        [COORD_W:0] ady_c;

    // Signed distances; one extra bit so the full grid span never overflows
    assign dx_c  = $signed({1'b0, target.x}) - $signed({1'b0, cur_head.x});
    assign dy_c  = $signed({1'b0, target.y}) - $signed({1'b0, cur_head.y});
    assign adx_c = dx_c[COORD_W] ? (COORD_W+1)'(-dx_c) : (COORD_W+1)'(dx_c);
    assign ady_c = dy_c[COORD_W] ? (COORD_W+1)'(-dy_c) : (COORD_W+1)'(dy_c);

    // Step selection
    always_comb begin
        next_head_c = cur_head;
        if ((adx_c >= ady_c) && (dx_c != '0)) begin
            if (!dx_c[COORD_W]) begin
                next_head_c.x      = cur_head.x + COORD_W'(1);
                next_head_c.orient = ORIENT_RIGHT;
            end else begin
                next_head_c.x      = cur_head.x - COORD_W'(1);
                next_head_c.orient = ORIENT_LEFT;
            end
        end else if (dy_c != '0) begin
            if (!dy_c[COORD_W]) begin
                next_head_c.y      = cur_head.y + COORD_W'(1);
                next_head_c.orient = ORIENT_DOWN;
            end else begin
                next_head_c.y      = cur_head.y - COORD_W'(1);
                next_head_c.orient = ORIENT_UP;
            end
        end
    end

endmodule

// File: rtl/dragon_controller.sv
// dragon_controller: sequences the dragon body block.
//   clk, reset         - clock, asynchronous active-high reset
//   frame_tick         - one-clk pulse per vsync
//   target_pos         - {x, y} player cell, sampled on the head-step clk
//   heal_req, hit_req  - level or pulse growth / damage requests
//   enable             - game running; 0 freezes movement and event service
//   movement_counter   - frame counter 0..MOVE_PERIOD-1
//   orien_and_position - {orient, x, y} head word
//   state_pulse        - MOVE/HEAL/HIT/IDLE one-clk pulses
//   dragon_length      - body segment count 0..MAX_LEN
//   dragon_dead        - sticky, set when a hit empties the body
module dragon_controller
    import dragon_pkg::*;
#(
    parameter logic [CNT_W-1:0] MOVE_PERIOD = 6'd8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic [POS_W-1:0]  target_pos,
    input  logic              heal_req,
    input  logic              hit_req,
    input  logic              enable,
    output logic [CNT_W-1:0]  movement_counter,
    output logic [HEAD_W-1:0] orien_and_position,
    output logic [1:0]        state_pulse,
    output logic [LEN_W-1:0]  dragon_length,
    output logic              dragon_dead
);

    fsm_state_t state;
    pulse_t     pulse_q;
    head_word_t head_q;
    head_word_t next_head_c;
    cell_t      target_c;
    logic       step_c;
    logic       heal_q;
    logic       hit_q;
    logic       heal_rise_c;
    logic       hit_rise_c;
    logic       heal_pend;
    logic       hit_pend;

    assign target_c           = target_pos;
    assign orien_and_position = head_q;
    assign state_pulse        = pulse_q;

    assign step_c      = frame_tick && enable && (movement_counter == MOVE_PERIOD - 6'd1);
    assign heal_rise_c = heal_req && !heal_q;
    assign hit_rise_c  = hit_req && !hit_q;

    dragon_head_stepper u_stepper (
        .cur_head    (head_q),
        .target      (target_c),
        .next_head_c (next_head_c)
    );

    // Frame counter and head register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            movement_counter <= '0;
            head_q           <= '0;
        end else if (frame_tick && enable) begin
            if (step_c) begin
                movement_counter <= '0;
                head_q           <= next_head_c;
            end else begin
                movement_counter <= movement_counter + 6'd1;
            end
        end
    end

    // Request capture, event FSM, length tracking and pulse register.
    // Later assignments override the defaults at the top of the else branch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            pulse_q       <= PULSE_IDLE;
            dragon_length <= '0;
            dragon_dead   <= 1'b0;
            heal_pend     <= 1'b0;
            hit_pend      <= 1'b0;
            heal_q        <= 1'b0;
            hit_q         <= 1'b0;
        end else begin
            heal_q <= heal_req;
            hit_q  <= hit_req;
            if (heal_rise_c) heal_pend <= 1'b1;
            if (hit_rise_c)  hit_pend  <= 1'b1;
            // MOVE only reaches the bus when the next state is IDLE or GAP
            pulse_q <= step_c ? PULSE_MOVE : PULSE_IDLE;

            case (state)
                // GAP arbitrates like IDLE so that queued events follow
                // back-to-back with a single IDLE clk between them
                S_IDLE, S_GAP: begin
                    if (enable && hit_pend) begin
                        state   <= S_HIT;
                        pulse_q <= PULSE_HIT;
                        if (!hit_rise_c) hit_pend <= 1'b0;
                        if (dragon_length != '0) begin
                            dragon_length <= dragon_length - 3'd1;
                            if (dragon_length == 3'd1) dragon_dead <= 1'b1;
                        end
                    end else if (enable && heal_pend) begin
                        if (!heal_rise_c) heal_pend <= 1'b0;
                        if (dragon_dead) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_HEAL;
                            pulse_q <= PULSE_HEAL;
                            if (dragon_length != MAX_LEN) begin
                                dragon_length <= dragon_length + 3'd1;
                            end
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HIT, S_HEAL: begin
                    state <= S_GAP;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dragon_controller.sv
// tb_dragon_controller: directed bench for dragon_controller with
// hand-computed expectations; inputs change and outputs are sampled on negedge.
module tb_dragon_controller;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic [7:0] target_pos;
    logic       heal_req;
    logic       hit_req;
    logic       enable;
    logic [5:0] movement_counter;
    logic [9:0] orien_and_position;
    logic [1:0] state_pulse;
    logic [2:0] dragon_length;
    logic       dragon_dead;

    int n_checks = 0;
    int n_fail   = 0;
    int move_seen = 0;
    int heal_seen = 0;
    int hit_seen  = 0;
    int base;

    dragon_controller dut (
        .clk                (clk),
        .reset              (reset),
        .frame_tick         (frame_tick),
        .target_pos         (target_pos),
        .heal_req           (heal_req),
        .hit_req            (hit_req),
        .enable             (enable),
        .movement_counter   (movement_counter),
        .orien_and_position (orien_and_position),
        .state_pulse        (state_pulse),
        .dragon_length      (dragon_length),
        .dragon_dead        (dragon_dead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters: the value sampled at a posedge is the one held over the previous clk
    always @(posedge clk) begin
        if (!reset) begin
            case (state_pulse)
                2'b00:   move_seen++;
                2'b01:   heal_seen++;
                2'b10:   hit_seen++;
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic period();
        repeat (8) tick();
    endtask

    task automatic heal();
        heal_req = 1'b1;
        @(negedge clk);
        heal_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic hit();
        hit_req = 1'b1;
        @(negedge clk);
        hit_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; frame_tick = 1'b0;
        target_pos = 8'h00; heal_req = 1'b0; hit_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cnt",   32'(movement_counter),   32'd0);
        check("rst_head",  32'(orien_and_position), 32'd0);
        check("rst_pulse", 32'(state_pulse),        32'd3);
        check("rst_len",   32'(dragon_length),      32'd0);
        check("rst_dead",  32'(dragon_dead),        32'd0);

        // Head (0,0) toward (3,0)
        reset = 1'b0; enable = 1'b1; target_pos = 8'h30;
        @(negedge clk);
        base = move_seen;
        repeat (7) tick();
        check("cnt7",  32'(movement_counter),   32'd7);
        check("head7", 32'(orien_and_position), 32'd0);
        tick();
        check("cnt8",  32'(movement_counter),   32'd0);
        check("head8", 32'(orien_and_position), 32'(10'b01_0001_0000));
        @(negedge clk);
        check("move1", 32'(move_seen - base),   32'd1);

        // Walk to (2,2), then down to (2,5) and hold
        target_pos = 8'h22;
        period(); check("to22_a", 32'(orien_and_position), 32'(10'b10_0001_0001));
        period(); check("to22_b", 32'(orien_and_position), 32'(10'b01_0010_0001));
        period(); check("to22_c", 32'(orien_and_position), 32'(10'b10_0010_0010));
        target_pos = 8'h25;
        period(); check("y3",   32'(orien_and_position), 32'(10'b10_0010_0011));
        period(); check("y4",   32'(orien_and_position), 32'(10'b10_0010_0100));
        period(); check("y5",   32'(orien_and_position), 32'(10'b10_0010_0101));
        period(); check("hold", 32'(orien_and_position), 32'(10'b10_0010_0101));

        // Tie goes horizontal (LEFT); pure vertical upward (UP)
        target_pos = 8'h03;
        period(); check("left", 32'(orien_and_position), 32'(10'b11_0001_0101));
        target_pos = 8'h10;
        period(); check("up",   32'(orien_and_position), 32'(10'b00_0001_0100));

        // enable=0 freezes the counter mid-period
        repeat (3) tick();
        check("cnt3", 32'(movement_counter), 32'd3);
        enable = 1'b0;
        repeat (2) tick();
        check("frz_cnt",  32'(movement_counter),   32'd3);
        check("frz_head", 32'(orien_and_position), 32'(10'b00_0001_0100));
        enable = 1'b1;
        repeat (5) tick();
        check("unfrz_cnt",  32'(movement_counter),   32'd0);
        check("unfrz_head", 32'(orien_and_position), 32'(10'b00_0001_0011));

        // Nine heals from 0 saturate at 7, every one pulsed
        base = heal_seen;
        repeat (9) heal();
        check("heal9_cnt", 32'(heal_seen - base), 32'd9);
        check("heal9_len", 32'(dragon_length),    32'd7);
        repeat (4) hit();
        check("len3", 32'(dragon_length), 32'd3);

        // Simultaneous heal and hit edges: HIT, IDLE, HEAL
        heal_req = 1'b1; hit_req = 1'b1;
        @(negedge clk); check("sim0", 32'(state_pulse), 32'd3);
        @(negedge clk); check("sim1_hit", 32'(state_pulse), 32'd2);
        check("sim1_len", 32'(dragon_length), 32'd2);
        @(negedge clk); check("sim2_gap", 32'(state_pulse), 32'd3);
        @(negedge clk); check("sim3_heal", 32'(state_pulse), 32'd1);
        check("sim3_len", 32'(dragon_length), 32'd3);
        heal_req = 1'b0; hit_req = 1'b0;
        @(negedge clk); check("sim4_idle", 32'(state_pulse), 32'd3);

        // Death at length 1, heal blocked afterwards, hit at length 0
        repeat (2) hit();
        check("len1", 32'(dragon_length), 32'd1);
        base = hit_seen;
        hit();
        check("die_hits", 32'(hit_seen - base), 32'd1);
        check("die_len",  32'(dragon_length),   32'd0);
        check("die_dead", 32'(dragon_dead),     32'd1);
        base = heal_seen;
        heal();
        check("dead_heal", 32'(heal_seen - base), 32'd0);
        check("dead_len",  32'(dragon_length),    32'd0);
        base = hit_seen;
        hit();
        check("hit0_cnt",  32'(hit_seen - base), 32'd1);
        check("hit0_len",  32'(dragon_length),   32'd0);
        check("hit0_dead", 32'(dragon_dead),     32'd1);

        // Async reset in the middle of a HEAL pulse with counter=5
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_dead", 32'(dragon_dead), 32'd0);
        repeat (5) tick();
        check("cnt5", 32'(movement_counter), 32'd5);
        heal_req = 1'b1;
        @(negedge clk);
        heal_req = 1'b0;
        @(negedge clk);
        check("pre_heal", 32'(state_pulse),   32'd1);
        check("pre_len",  32'(dragon_length), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_pulse", 32'(state_pulse),        32'd3);
        check("arst_cnt",   32'(movement_counter),   32'd0);
        check("arst_len",   32'(dragon_length),      32'd0);
        check("arst_head",  32'(orien_and_position), 32'd0);
        check("arst_dead",  32'(dragon_dead),        32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("restart_cnt",   32'(movement_counter), 32'd1);
        check("restart_len",   32'(dragon_length),    32'd0);
        check("restart_pulse", 32'(state_pulse),      32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dragon_controller.md
Name: dragon_controller

Overview:
- Sequences the dragon body shift-register block: generates its movement_counter, its 10-bit head {orientation, position} word and its one-cycle-wide state pulses (MOVE/HEAL/HIT/IDLE).
- Steps the dragon head one grid cell toward a target (the player) on a programmable frame cadence.
- Arbitrates asynchronous heal/hit requests into legal single-cycle pulses.
- Tracks the body length so that the body block's Display_en is never over- or under-shifted.

Parameters:
- MOVE_PERIOD, 6'd8: frames per movement step; legal range 3..63.
- SHIFT_POINT, 6'd2: counter value at which the body block shifts. Fixed contract with the body block.
- MAX_LEN, 3'd7: maximum body segments.

Ports:
- clk  in  1: system clock
- reset  in  1: asynchronous, active-high reset
- frame_tick  in  1: one-clk pulse per vsync rising edge
- target_pos  in  8: {x[3:0], y[3:0]} player cell, sampled at step time
- heal_req  in  1: level or pulse; request one segment growth
- hit_req  in  1: level or pulse; request one segment loss
- enable  in  1: game running; 0 freezes movement and blocks event pulses
- movement_counter  out  6: frame counter 0..MOVE_PERIOD-1
- orien_and_position  out  10: {orient[1:0], x[3:0], y[3:0]} head word
- state_pulse  out  2: 00 MOVE, 01 HEAL, 10 HIT, 11 IDLE
- dragon_length  out  3: current segment count 0..MAX_LEN
- dragon_dead  out  1: sticky; set when length reaches 0 via HIT

Behaviour:
Reset values:
- movement_counter=0
- orien_and_position=10'b00_0000_0000
- state_pulse=IDLE
- dragon_length=0
- dragon_dead=0
- hit_pend=0, heal_pend=0
- FSM in S_IDLE

Frame counter:
- Advances on frame_tick && enable.
- Wraps MOVE_PERIOD-1 -> 0.
- Frozen when enable=0.

Head step:
- Occurs on the clk where frame_tick && enable && movement_counter==MOVE_PERIOD-1.
- The new head word is registered one clk later, so it is stable long before counter==SHIFT_POINT.
- dx = tx - x and dy = ty - y, signed 5-bit.
- If |dx| >= |dy| and dx != 0: x±1, orient = RIGHT(01) or LEFT(11).
- Else if dy != 0: y±1, orient = DOWN(10) when dy > 0, UP(00) when dy < 0.
- If dx = dy = 0: position and orient held.
- Arithmetic never wraps; a step is at most one cell, and the target is in-grid.

Request capture:
- heal_req/hit_req rising edges set the pending flags heal_pend/hit_pend.
- Each pending flag holds a single request; further edges while pending are dropped.

FSM states: S_IDLE, S_HIT, S_HEAL, S_GAP.
- S_IDLE, enable=1: hit_pend -> S_HIT; else heal_pend -> S_HEAL. Hit has priority.
- S_HIT: state_pulse=HIT for exactly 1 clk; clear hit_pend.
  - If length > 0: length-1. If the new length is 0, set dragon_dead.
  - If length == 0: request consumed, length unchanged, dead unchanged.
  - Go to S_GAP.
- S_HEAL: state_pulse=HEAL for 1 clk; clear heal_pend.
  - Length+1, saturating at MAX_LEN; the pulse is still issued at MAX_LEN.
  - Go to S_GAP.
- S_GAP: state_pulse=IDLE for 1 clk, guaranteeing pulses are separated. Go to S_IDLE.

state_pulse:
- Outside the HIT/HEAL clocks it is IDLE, never MOVE.
- MOVE is issued for 1 clk coincident with the head-step clk, only when FSM is in S_IDLE or S_GAP.
- Otherwise the MOVE pulse is suppressed; the head still steps.

Simultaneous events:
- Heal and hit edges on the same clk set both flags; HIT is served first, then GAP, then HEAL.
- An edge arriving in the same clk its flag is cleared re-sets the flag (new request wins).

dragon_dead:
- Blocks further HEAL service: heal_pend is cleared without a pulse.
- Cleared only by reset.

enable=0:
- Pending flags retained.
- An in-flight S_HIT/S_HEAL/S_GAP sequence completes.

Reset mid-operation:
- All registers return to reset values immediately (async).
- state_pulse reads IDLE within the same cycle.

Decomposition:
- Shared package dragon_pkg: state-pulse codes (MOVE/HEAL/HIT/IDLE), orientation codes (UP/RIGHT/DOWN/LEFT), the head-word field layout, and MAX_LEN.
- Sub-module dragon_head_stepper (purely combinational): current head + target -> next head word. Used once here and reusable by the AI/collision logic.

Test Plan:
- Reset, then 8 frame_ticks with head (0,0) and target (3,0) -> after tick 8, orien_and_position=10'b01_0001_0000, one MOVE pulse, counter back to 0.
- Target (2,5) from head (2,2) with 3 step periods -> y goes 3, 4, 5, orient=DOWN; fourth period holds (2,5).
- heal_req and hit_req rising on the same clk with length=3 -> HIT, IDLE, HEAL pulses on consecutive clks; final length=3.
- 9 heal pulses from length 0 -> length saturates at 7; 9 HEAL pulses are observed.
- Length=1, hit_req -> one HIT pulse, length=0, dragon_dead=1; a later heal_req produces no pulse and length stays 0.
- Assert reset mid S_HEAL with counter=5 -> all outputs return to reset values asynchronously; after release the counter restarts from 0.
